synaptic_accumulator: RTL and testbench
=======================================

# synaptic_accumulator

Receiver for weighted synaptic events produced by the synapse array. Each event (neuron ID, magnitude, excitatory/inhibitory flag) is summed with saturation into a per-neuron signed accumulator held in on-chip RAM. On each timestep boundary, every accumulator is drained in neuron order to the neuron array over a valid/ready stream and cleared for the next timestep.

## Interface
- NUM_NEURONS, 64, number of accumulators
- WEIGHT_WIDTH, 8, unsigned event magnitude width
- ACC_WIDTH, 16, signed accumulator width; must be greater than WEIGHT_WIDTH
- NEURON_ID_WIDTH, $clog2(NUM_NEURONS), neuron index width

Reset is rst_n, synchronous, active-low. Clock is clk.

- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  synaptic event present
- in_neuron_id  in  NEURON_ID_WIDTH  target accumulator
- in_weight  in  WEIGHT_WIDTH  unsigned magnitude
- in_exc_inh  in  1  0 = excitatory (add), 1 = inhibitory (subtract)
- in_ready  out  1  event accepted this cycle if in_valid is also high
- timestep_end  in  1  single-cycle pulse; request drain
- out_valid  out  1  drained accumulator presented
- out_ready  in  1  downstream accepts
- out_neuron_id  out  NEURON_ID_WIDTH  index of drained accumulator
- out_current  out  ACC_WIDTH  signed accumulated value
- drain_done  out  1  single-cycle pulse after last neuron is handed off
- drop_count  out  16  saturating count of events seen while in_ready was 0

## Operation
- States:
  - INIT: write 0 to addresses 0..NUM_NEURONS-1, one per cycle, then go to ACCUM. Entered on reset; in_ready=0 throughout.
  - ACCUM: in_ready=1. Events are accepted. On timestep_end, go to FLUSH.
  - FLUSH: in_ready=0. Wait until the accumulate pipeline is empty, then go to DRAIN_RD with index=0.
  - DRAIN_RD: issue a RAM read of index, then go to DRAIN_OUT.
  - DRAIN_OUT: hold out_valid with the read data. On handshake, write 0 to index.
    - If index is NUM_NEURONS-1: pulse drain_done and go to ACCUM.
    - Otherwise: increment index and go to DRAIN_RD.
- Accumulate pipeline (throughput 1 event per cycle):
  - S0: accept the event and issue the RAM read.
  - S1: read data returns; compute; write back.
- Hazard: if the S0 neuron equals the S1 neuron, forward the S1 result as the operand instead of the RAM data. Back-to-back events to the same neuron must sum correctly.
- Arithmetic:
  - Zero-extend the weight to ACC_WIDTH+1 bits and sign-extend the accumulator.
  - Add if exc_inh=0, subtract if exc_inh=1.
  - Clamp to the range [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
- All NUM_NEURONS entries are emitted every drain, including zero values.
- timestep_end arriving outside ACCUM (during INIT, FLUSH or DRAIN) is latched one-deep. A latched request starts a new FLUSH on the first ACCUM cycle. Further pulses while one is latched are discarded.
- timestep_end together with in_valid in ACCUM: the event is accepted and included in this drain.
- drop_count increments when in_valid=1 and in_ready=0; it holds at 0xFFFF.
- An out-of-range in_neuron_id (NUM_NEURONS not a power of 2) drops the event and increments drop_count.

## Timing
- Reset values: in_ready=0, out_valid=0, out_neuron_id=0, out_current=0, drain_done=0, drop_count=0.
- INIT lasts exactly NUM_NEURONS cycles after rst_n deasserts; in_ready rises on the following cycle.
- Event latency: an event accepted at cycle t is written at t+1 and visible to a drain read from t+2.
- FLUSH lasts at most 2 cycles.
- Drain takes a minimum of 2 cycles per neuron with out_ready held at 1.
- out_valid, out_neuron_id and out_current are stable while out_valid=1 and out_ready=0.
- drain_done is asserted in the cycle after the final handshake.
- rst_n asserted mid-drain or mid-accumulate aborts immediately. Any latched timestep_end is discarded, and INIT re-clears all entries.

## Structure
- Shared snn_pkg holds:
  - ACC_WIDTH default
  - state encoding (INIT, ACCUM, FLUSH, DRAIN_RD, DRAIN_OUT)
  - saturating add/sub function, reused by the neuron array
- Sub-module acc_ram: single-clock simple dual-port RAM, NUM_NEURONS x ACC_WIDTH, 1-cycle registered read, no reset (cleared by INIT), inferred as BRAM or LUTRAM.
- The write port is muxed between the accumulate write-back, INIT clear and drain clear; these never overlap by construction.

## Test plan
- Post-reset clear: release rst_n, wait for in_ready, pulse timestep_end → 64 outputs in order 0..63, all out_current=0, then drain_done.
- Mixed accumulation: events to neuron 5 of +10, +20, inhibitory 7, then drain → neuron 5 = 23, all others 0.
- Forwarding: 4 consecutive-cycle events to neuron 9 with weight 255, excitatory → 1020. The same test with alternating neurons 9/10 → 510 each.
- Saturation: 200 events of +255 to neuron 0 → 32767. 200 inhibitory events of 255 to neuron 1 → -32768. A following +1 to neuron 1 → -32767.
- Backpressure and drops: out_ready toggled randomly during a drain → outputs stable while stalled and the sequence is complete. 3 events during the drain → drop_count=3. A second drain → all entries 0.
- Latched timestep / reset abort: timestep_end pulsed twice during a drain → exactly one extra drain. rst_n asserted at neuron 30 of a drain → out_valid=0 next cycle, INIT runs, later drain → all entries 0.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath: accumulator width,
// accumulator FSM encoding and the saturating add/sub used by the neuron array.
package snn_pkg;

    localparam int ACC_WIDTH_DEF = 16;
    localparam int SAT_CALC_W    = 34;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_ACCUM,
        ST_FLUSH,
        ST_DRAIN_RD,
        ST_DRAIN_OUT
    } acc_state_t;

    // Width-generic saturating add/sub: the caller sign-extends the
    // accumulator, zero-extends the magnitude and truncates the result to acc_w bits.
    function automatic logic signed [31:0] sat_addsub(
        input logic signed [31:0] acc,
        input logic        [31:0] weight,
        input logic               sub,
        input int unsigned        acc_w
    );
        logic signed [SAT_CALC_W-1:0] a;
        logic signed [SAT_CALC_W-1:0] w;
        logic signed [SAT_CALC_W-1:0] s;
        logic signed [SAT_CALC_W-1:0] max_v;
        logic signed [SAT_CALC_W-1:0] min_v;
        a     = SAT_CALC_W'(acc);
        w     = $signed({2'b00, weight});
        s     = sub ? (a - w) : (a + w);
        max_v = $signed((SAT_CALC_W'(1) << (acc_w - 1)) - SAT_CALC_W'(1));
        min_v = ~max_v;
        if (s > max_v) begin
            return max_v[31:0];
        end else if (s < min_v) begin
            return min_v[31:0];
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/synaptic_accumulator_if.sv
// Event input stream and drained-current output stream of the synaptic accumulator.
interface synaptic_accumulator_if #(
    parameter int NEURON_ID_WIDTH = 6,
    parameter int WEIGHT_WIDTH    = 8,
    parameter int ACC_WIDTH       = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic [NEURON_ID_WIDTH-1:0]  in_neuron_id;
    logic [WEIGHT_WIDTH-1:0]     in_weight;
    logic                        in_exc_inh;

    logic                        out_valid;
    logic                        out_ready;
    logic [NEURON_ID_WIDTH-1:0]  out_neuron_id;
    logic signed [ACC_WIDTH-1:0] out_current;

    modport slave (
        input  in_valid, in_neuron_id, in_weight, in_exc_inh, out_ready,
        output in_ready, out_valid, out_neuron_id, out_current
    );

    modport master (
        output in_valid, in_neuron_id, in_weight, in_exc_inh, out_ready,
        input  in_ready, out_valid, out_neuron_id, out_current
    );
endinterface

// File: rtl/synaptic_accumulator_acc_ram.sv
// Simple dual-port accumulator storage with a registered read; contents are
// undefined after configuration and cleared by the owner's INIT sweep.
module acc_ram #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/synaptic_accumulator.sv
// Per-neuron saturating accumulation of synaptic events with a per-timestep
// in-order drain that hands each accumulator downstream and clears it.
module synaptic_accumulator
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS     = 64,
    parameter int WEIGHT_WIDTH    = 8,
    parameter int ACC_WIDTH       = ACC_WIDTH_DEF,
    parameter int NEURON_ID_WIDTH = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    synaptic_accumulator_if.slave  bus,
    input  logic                   timestep_end,
    output logic                   drain_done,
    output logic [15:0]            drop_count
);
    localparam logic [NEURON_ID_WIDTH-1:0] LAST_IDX = NEURON_ID_WIDTH'(NUM_NEURONS - 1);

    acc_state_t                  state_reg, state_next;
    logic [NEURON_ID_WIDTH-1:0]  idx_reg, idx_next;
    logic                        pend_reg, pend_next;
    logic                        done_reg;
    logic                        drain_last;
    logic [15:0]                 drop_reg;

    logic                        s1_valid_reg;
    logic [NEURON_ID_WIDTH-1:0]  s1_id_reg;
    logic [WEIGHT_WIDTH-1:0]     s1_weight_reg;
    logic                        s1_sub_reg;
    logic                        fwd_sel_reg;
    logic signed [ACC_WIDTH-1:0] fwd_data_reg;

    logic signed [ACC_WIDTH-1:0] operand;
    logic signed [ACC_WIDTH-1:0] s1_result;
    logic [ACC_WIDTH-1:0]        ram_rdata;
    logic [ACC_WIDTH-1:0]        ram_wdata;
    logic [NEURON_ID_WIDTH-1:0]  ram_waddr;
    logic [NEURON_ID_WIDTH-1:0]  ram_raddr;
    logic                        ram_we;

    logic                        in_range;
    logic                        accept;
    logic                        drop_event;

    generate
        if ((1 << NEURON_ID_WIDTH) == NUM_NEURONS) begin : g_pow2
            assign in_range = 1'b1;
        end else begin : g_range
            assign in_range = ({1'b0, bus.in_neuron_id} < (NEURON_ID_WIDTH + 1)'(NUM_NEURONS));
        end
    endgenerate

    assign accept     = bus.in_valid && (state_reg == ST_ACCUM) && in_range;
    assign drop_event = bus.in_valid && !accept;

    // A same-neuron event right behind another would read the pre-write value,
    // so the previous result is captured at accept time and used instead.
    assign operand   = fwd_sel_reg ? fwd_data_reg : $signed(ram_rdata);
    assign s1_result = ACC_WIDTH'(sat_addsub(32'(operand), 32'(s1_weight_reg),
                                             s1_sub_reg, ACC_WIDTH));

    acc_ram #(
        .DEPTH  (NUM_NEURONS),
        .DATA_W (ACC_WIDTH),
        .ADDR_W (NEURON_ID_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_INIT;
            idx_reg   <= '0;
            pend_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            pend_reg  <= pend_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        pend_next  = pend_reg;
        drain_last = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = idx_reg;
        ram_wdata  = '0;
        ram_raddr  = bus.in_neuron_id;
        case (state_reg)
            ST_INIT: begin
                ram_we = 1'b1;
                if (idx_reg == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = ST_ACCUM;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            ST_ACCUM: begin
                if (timestep_end || pend_reg) begin
                    pend_next  = 1'b0;
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!s1_valid_reg) begin
                    idx_next   = '0;
                    state_next = ST_DRAIN_RD;
                end
            end
            ST_DRAIN_RD: begin
                ram_raddr  = idx_reg;
                state_next = ST_DRAIN_OUT;
            end
            ST_DRAIN_OUT: begin
                ram_raddr = idx_reg;
                if (bus.out_ready) begin
                    ram_we = 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        drain_last = 1'b1;
                        idx_next   = '0;
                        state_next = ST_ACCUM;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = ST_DRAIN_RD;
                    end
                end
            end
            default: state_next = ST_INIT;
        endcase
        if (timestep_end && (state_reg != ST_ACCUM)) begin
            pend_next = 1'b1;
        end
        if (s1_valid_reg) begin
            ram_we    = 1'b1;
            ram_waddr = s1_id_reg;
            ram_wdata = s1_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_id_reg     <= '0;
            s1_weight_reg <= '0;
            s1_sub_reg    <= 1'b0;
            fwd_sel_reg   <= 1'b0;
            fwd_data_reg  <= '0;
            done_reg      <= 1'b0;
            drop_reg      <= '0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_id_reg     <= bus.in_neuron_id;
                s1_weight_reg <= bus.in_weight;
                s1_sub_reg    <= bus.in_exc_inh;
                fwd_sel_reg   <= s1_valid_reg && (s1_id_reg == bus.in_neuron_id);
                fwd_data_reg  <= s1_result;
            end
            done_reg <= drain_last;
            if (drop_event && (drop_reg != 16'hFFFF)) begin
                drop_reg <= drop_reg + 16'd1;
            end
        end
    end

    assign bus.in_ready      = (state_reg == ST_ACCUM);
    assign bus.out_valid     = (state_reg == ST_DRAIN_OUT);
    assign bus.out_neuron_id = bus.out_valid ? idx_reg : '0;
    assign bus.out_current   = bus.out_valid ? $signed(ram_rdata) : '0;
    assign drain_done        = done_reg;
    assign drop_count        = drop_reg;

endmodule

// File: tb/tb_synaptic_accumulator.sv
// Directed and random bench for synaptic_accumulator against an array-based
// model of per-neuron clamped sums; one line printed per drain.
module tb_synaptic_accumulator;
    localparam int N   = 64;
    localparam int WW  = 8;
    localparam int AW  = 16;
    localparam int IDW = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        timestep_end = 1'b0;
    logic        drain_done;
    logic [15:0] drop_count;

    synaptic_accumulator_if #(.NEURON_ID_WIDTH(IDW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW)) bus ();

    synaptic_accumulator #(
        .NUM_NEURONS(N), .WEIGHT_WIDTH(WW), .ACC_WIDTH(AW), .NEURON_ID_WIDTH(IDW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .timestep_end (timestep_end),
        .drain_done   (drain_done),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int model [N];
    int drop_exp = 0;
    int drain_no = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N; i++) model[i] = 0;
    endtask

    task automatic ev(input int id, input int w, input bit inh, input bit ts = 1'b0);
        bus.in_valid     = 1'b1;
        bus.in_neuron_id = IDW'(id);
        bus.in_weight    = WW'(w);
        bus.in_exc_inh   = inh;
        timestep_end     = ts;
        model[id]        = clamp(model[id] + (inh ? -w : w));
        @(negedge clk);
        bus.in_valid = 1'b0;
        timestep_end = 1'b0;
    endtask

    task automatic init_wait();
        int c = 0;
        while (!bus.in_ready && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check("init_cycles", c, N);
    endtask

    task automatic wait_ready();
        int c = 0;
        while (!bus.in_ready && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("in_ready_rise", bus.in_ready, 1);
    endtask

    task automatic drain(input bit pulse, input bit stall, input int n_drops,
                         input int n_ts, input int abort_k);
        int k = 0;
        int cyc = 0;
        int drops = 0;
        int ts_sent = 0;
        bit held = 1'b0;
        logic [IDW-1:0]       h_id = '0;
        logic signed [AW-1:0] h_cur = '0;
        if (pulse) begin
            timestep_end = 1'b1;
            @(negedge clk);
            timestep_end = 1'b0;
        end
        while (k < N) begin
            bus.in_valid = 1'b0;
            timestep_end = 1'b0;
            if (abort_k >= 0 && k == abort_k) begin
                rst_n = 1'b0;
                @(negedge clk);
                check("abort_out_valid", bus.out_valid, 0);
                check("abort_drop_count", drop_count, 0);
                rst_n = 1'b1;
                bus.out_ready = 1'b1;
                clear_model();
                drop_exp = 0;
                $display("drain %0d aborted by reset at neuron %0d", drain_no, k);
                drain_no++;
                return;
            end
            if (drops < n_drops && k >= 5) begin
                check("drain_in_ready", bus.in_ready, 0);
                bus.in_valid     = 1'b1;
                bus.in_neuron_id = IDW'($urandom_range(0, N - 1));
                bus.in_weight    = WW'($urandom_range(0, 255));
                bus.in_exc_inh   = 1'($urandom_range(0, 1));
                drop_exp++;
                drops++;
            end
            if (ts_sent < n_ts && k >= 20 * (ts_sent + 1)) begin
                timestep_end = 1'b1;
                ts_sent++;
            end
            bus.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_id", bus.out_neuron_id, h_id);
                check("stall_current", bus.out_current, h_cur);
                held = 1'b0;
            end
            check("done_low_in_drain", drain_done, 0);
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    check("out_id", bus.out_neuron_id, k);
                    check("out_current", bus.out_current, model[k]);
                    k++;
                end else begin
                    held  = 1'b1;
                    h_id  = bus.out_neuron_id;
                    h_cur = bus.out_current;
                end
            end
            @(negedge clk);
            cyc++;
            if (cyc > 4000) begin
                check("drain_timeout", k, N);
                break;
            end
        end
        bus.in_valid  = 1'b0;
        timestep_end  = 1'b0;
        bus.out_ready = 1'b1;
        if (k == N) begin
            check("drain_done_pulse", drain_done, 1);
            @(negedge clk);
            check("drain_done_clear", drain_done, 0);
        end
        $display("drain %0d: %0d outputs in %0d cycles", drain_no, k, cyc);
        drain_no++;
        clear_model();
    endtask

    initial begin
        int seen;
        bus.in_valid     = 1'b0;
        bus.in_neuron_id = '0;
        bus.in_weight    = '0;
        bus.in_exc_inh   = 1'b0;
        bus.out_ready    = 1'b1;
        clear_model();

        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_id", bus.out_neuron_id, 0);
        check("rst_out_current", bus.out_current, 0);
        check("rst_drain_done", drain_done, 0);
        check("rst_drop_count", drop_count, 0);
        rst_n = 1'b1;
        init_wait();

        drain(1'b1, 1'b0, 0, 0, -1);

        wait_ready();
        ev(5, 10, 1'b0);
        ev(5, 20, 1'b0);
        ev(5, 7, 1'b1);
        drain(1'b1, 1'b0, 0, 0, -1);

        wait_ready();
        for (int i = 0; i < 4; i++) ev(9, 255, 1'b0);
        drain(1'b1, 1'b0, 0, 0, -1);
        wait_ready();
        for (int i = 0; i < 4; i++) ev(9 + (i % 2), 255, 1'b0);
        drain(1'b1, 1'b0, 0, 0, -1);

        wait_ready();
        for (int i = 0; i < 200; i++) ev(0, 255, 1'b0);
        for (int i = 0; i < 200; i++) ev(1, 255, 1'b1);
        ev(1, 1, 1'b0, 1'b1);
        drain(1'b0, 1'b0, 0, 0, -1);
        check("drop_none", drop_count, 0);

        wait_ready();
        for (int i = 0; i < 80; i++) begin
            ev($urandom_range(0, 7), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain(1'b1, 1'b1, 3, 0, -1);
        check("drop_three", drop_count, drop_exp);
        wait_ready();
        drain(1'b1, 1'b0, 0, 0, -1);

        wait_ready();
        for (int i = 0; i < 40; i++)
            ev($urandom_range(0, N - 1), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
        drain(1'b1, 1'b1, 0, 2, -1);
        drain(1'b0, 1'b0, 0, 0, -1);
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("no_third_drain", seen, 0);
        check("ready_after_extra", bus.in_ready, 1);

        for (int i = 0; i < 30; i++)
            ev($urandom_range(0, N - 1), $urandom_range(1, 255), 1'b0);
        drain(1'b1, 1'b1, 0, 1, 30);
        init_wait();
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("pending_discarded", seen, 0);
        drain(1'b1, 1'b0, 0, 0, -1);
        check("drop_after_reset", drop_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
